// File: rtl/rng_sample_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rng_sample_scheduler_pkg
// Description : Shared sizing constants and FSM state encodings for the
//               RNG sample scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rng_sample_scheduler_pkg;

    // Default sizing of the shared RNG pipeline and its scheduler
    localparam int RNG_BY          = 16;
    localparam int RNG_LAT         = 3;
    localparam int RNG_SCHED_NREQ  = 4;
    localparam int RNG_SCHED_CNT_W = 8;

    // Scheduler FSM encoding
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t c_ST_IDLE  = 2'd0;
    localparam sched_state_t c_ST_ISSUE = 2'd1;
    localparam sched_state_t c_ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rng_sample_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rng_sample_scheduler_rr_arbiter
// Description : Combinational round-robin pick. Searches upward (mod NREQ)
//               starting one past the last winner and returns the first set
//               request as a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_sample_scheduler_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_pos;

    // Rotating priority search; the last winner is visited last
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = IDX_W'((int'(i_rr_ptr) + k) % NREQ);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_grant_idx    = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rng_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rng_sample_scheduler
// Description : Shares one non-uniform RNG pipeline among NREQ consumers.
//               Grants one burst at a time round-robin, advances the pipeline
//               once per cycle for the burst, and routes returning samples to
//               their owner through a LAT-deep tag delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_sample_scheduler
    import rng_sample_scheduler_pkg::*;
#(
    parameter int NREQ  = RNG_SCHED_NREQ,
    parameter int BY    = RNG_BY,
    parameter int CNT_W = RNG_SCHED_CNT_W,
    parameter int LAT   = RNG_LAT
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_cnt,
    output logic [NREQ-1:0]       grant,
    output logic                  urng_en,
    input  logic [BY-1:0]         pipe_data,
    input  logic                  pipe_valid,
    output logic [BY-1:0]         sample_data,
    output logic                  sample_valid,
    output logic [NREQ-1:0]       sample_dst,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IF_W  = $clog2(LAT + 1) + 1;
    localparam logic [IF_W-1:0]  c_IF_ONE  = IF_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [CNT_W-1:0] w_req_cnt [NREQ];
    logic [NREQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic             w_accept;
    logic             w_urng_en;
    logic             w_busy;
    logic             w_tag_exit;
    logic             w_drain_done;
    logic [NREQ-1:0]  w_exit_dst;
    logic [NREQ-1:0]  w_gidx_oh;

    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_rr;
    logic [IDX_W-1:0] r_gidx;
    logic             r_tag_v  [LAT];
    logic [IDX_W-1:0] r_tag_id [LAT];
    logic [IF_W-1:0]  r_inflight;
    logic [BY-1:0]    r_sample_data;
    logic             r_sample_valid;
    logic [NREQ-1:0]  r_sample_dst;
    logic             r_err;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_unpack
            assign w_req_cnt[gi] = req_cnt[gi*CNT_W +: CNT_W];
        end
    endgenerate

    rng_sample_scheduler_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req       (req),
        .i_rr_ptr    (r_rr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_any       (w_arb_any)
    );

    // A burst is only accepted from IDLE, so bursts never overlap
    assign w_accept     = (r_state == c_ST_IDLE) && w_arb_any;
    assign w_tag_exit   = r_tag_v[LAT-1];
    assign w_drain_done = (r_state == c_ST_DRAIN) && (r_inflight == '0) && !w_tag_exit;

    // One-hot decode of the exiting tag owner and of the current burst owner
    always_comb begin
        w_exit_dst                      = '0;
        w_exit_dst[r_tag_id[LAT-1]]     = 1'b1;
        w_gidx_oh                       = '0;
        w_gidx_oh[r_gidx]               = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: a zero-length burst goes straight to DRAIN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_req_cnt[w_arb_idx] != '0) ? c_ST_ISSUE : c_ST_DRAIN;
                end
            end
            c_ST_ISSUE: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM outputs: advance the pipeline every ISSUE cycle
    always_comb begin
        w_urng_en = (r_state == c_ST_ISSUE);
        w_busy    = (r_state != c_ST_IDLE) || (r_inflight != '0);
    end

    // Grant/done pulses, burst length and round-robin pointer
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_grant <= '0;
            r_done  <= '0;
            r_cnt   <= '0;
            r_rr    <= IDX_W'(NREQ - 1);
            r_gidx  <= '0;
        end else begin
            r_grant <= w_accept ? w_arb_grant : '0;
            r_done  <= w_drain_done ? w_gidx_oh : '0;
            if (w_accept) begin
                r_cnt  <= w_req_cnt[w_arb_idx];
                r_rr   <= w_arb_idx;
                r_gidx <= w_arb_idx;
            end else if (w_urng_en) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    // Tag delay line: stage LAT-1 lines up with the matching pipe_valid
    always_ff @(posedge clock) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_urng_en;
            r_tag_id[0] <= r_gidx;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Samples in flight: issue adds one, tag exit removes one
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_urng_en, w_tag_exit})
                2'b10:   r_inflight <= r_inflight + c_IF_ONE;
                2'b01:   r_inflight <= r_inflight - c_IF_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Sample capture is driven by the tag; pipe_valid only feeds the error flag
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_sample_dst   <= '0;
            r_err          <= 1'b0;
        end else begin
            r_sample_valid <= w_tag_exit;
            r_sample_dst   <= w_tag_exit ? w_exit_dst : '0;
            if (w_tag_exit) begin
                r_sample_data <= pipe_data;
            end
            if (w_tag_exit != pipe_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign grant        = r_grant;
    assign done         = r_done;
    assign urng_en      = w_urng_en;
    assign busy         = w_busy;
    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign sample_dst   = r_sample_dst;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rng_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_sample_scheduler
// Description : Self-checking bench for rng_sample_scheduler. A fixed-latency
//               pipeline model feeds random samples back; a burst-level
//               schedule model predicts grants, issue cycles, sample routing
//               and done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_sample_scheduler;

    localparam int NREQ  = 4;
    localparam int BY    = 16;
    localparam int CNT_W = 8;
    localparam int LAT   = 3;

    logic                  clock = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] req_cnt = '0;
    logic [NREQ-1:0]       grant;
    logic                  urng_en;
    logic [BY-1:0]         pipe_data = '0;
    logic                  pipe_valid = 1'b0;
    logic [BY-1:0]         sample_data;
    logic                  sample_valid;
    logic [NREQ-1:0]       sample_dst;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int model_rr = NREQ - 1;
    int drop_req = 0;
    int drop_done = 0;
    logic [NREQ*CNT_W-1:0] rnd_cnts;

    // Event logs filled by the monitor (never trimmed; tests read from an offset)
    logic [NREQ-1:0] g_val [$];
    int              g_cyc [$];
    logic [NREQ-1:0] d_val [$];
    int              d_cyc [$];
    int              en_cyc [$];
    logic [BY-1:0]   s_data [$];
    logic [NREQ-1:0] s_dst [$];
    int              s_cyc [$];
    logic [BY-1:0]   p_data [$];
    bit              sh [LAT];

    rng_sample_scheduler #(
        .NREQ  (NREQ),
        .BY    (BY),
        .CNT_W (CNT_W),
        .LAT   (LAT)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .req          (req),
        .req_cnt      (req_cnt),
        .grant        (grant),
        .urng_en      (urng_en),
        .pipe_data    (pipe_data),
        .pipe_valid   (pipe_valid),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_dst   (sample_dst),
        .done         (done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clock = ~clock;

    // Monitor and pipeline model: pipe_valid in cycle c equals urng_en in cycle c-LAT
    always @(negedge clock) begin : mon
        bit out_v;
        cyc = cyc + 1;
        if (grant != '0) begin g_val.push_back(grant); g_cyc.push_back(cyc); end
        if (done != '0) begin d_val.push_back(done); d_cyc.push_back(cyc); end
        if (urng_en) en_cyc.push_back(cyc);
        if (sample_valid) begin
            s_data.push_back(sample_data);
            s_dst.push_back(sample_dst);
            s_cyc.push_back(cyc);
        end
        if (!rst) begin
            for (int i = 0; i < LAT; i++) sh[i] = 1'b0;
            pipe_valid = 1'b0;
        end else begin
            out_v = sh[LAT-1];
            for (int i = LAT - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = urng_en;
            if (out_v && (drop_req > drop_done)) begin
                drop_done = drop_done + 1;
                out_v = 1'b0;
            end
            pipe_valid = out_v;
            pipe_data  = BY'($urandom);
            if (out_v) p_data.push_back(pipe_data);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        tick();
        tick();
        tests++;
        if ({grant, done, sample_dst, sample_valid, urng_en, busy, err, sample_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got grant=%b done=%b dst=%b sv=%b en=%b busy=%b err=%b data=%h, expected all 0",
                     grant, done, sample_dst, sample_valid, urng_en, busy, err, sample_data);
        end
        rst = 1'b1;
        model_rr = NREQ - 1;
        tick();
        tests++;
        if (busy !== 1'b0 || urng_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b en=%b, expected 0 0", busy, urng_en);
        end
    endtask

    // Raise mask, keep it until nb grants are seen, compare against the schedule model
    task automatic test_bursts(input string name, input logic [NREQ-1:0] mask,
                               input logic [NREQ*CNT_W-1:0] cnts, input int nb, input int budget);
        logic [NREQ-1:0] exp_g [$];
        int              exp_gc [$];
        int              exp_en [$];
        int              exp_sc [$];
        logic [NREQ-1:0] exp_sd [$];
        int              exp_dc [$];
        int g0, d0, e0, s0, p0, t, td, p, n, ngr;
        bit timeout;
        g0 = g_val.size(); d0 = d_val.size(); e0 = en_cyc.size();
        s0 = s_data.size(); p0 = p_data.size();
        t = cyc + 2;
        for (int k = 0; k < nb; k++) begin
            p = -1;
            for (int j = 1; j <= NREQ && p < 0; j++)
                if (mask[(model_rr + j) % NREQ]) p = (model_rr + j) % NREQ;
            n = int'(cnts[p*CNT_W +: CNT_W]);
            exp_g.push_back(NREQ'(1 << p));
            exp_gc.push_back(t);
            for (int i = 0; i < n; i++) begin
                exp_en.push_back(t + i);
                exp_sc.push_back(t + LAT + 1 + i);
                exp_sd.push_back(NREQ'(1 << p));
            end
            td = (n == 0) ? t + 1 : t + LAT + n + 1;
            exp_dc.push_back(td);
            t = td + 1;
            model_rr = p;
        end

        req_cnt = cnts;
        req = mask;
        ngr = 0;
        timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (grant != '0) ngr++;
            if (ngr >= nb) req = '0;
            if (req == '0 && !busy) begin timeout = 1'b0; break; end
        end
        req = '0;
        tick();
        tick();

        tests++;
        if (timeout) begin fails++; $display("FAIL %s timeout: got busy after %0d cycles, expected idle", name, budget); end
        tests++;
        if (g_val.size() - g0 != exp_g.size()) begin fails++;
            $display("FAIL %s grant_count: got %0d expected %0d", name, g_val.size() - g0, exp_g.size()); end
        tests++;
        if (en_cyc.size() - e0 != exp_en.size()) begin fails++;
            $display("FAIL %s urng_en_count: got %0d expected %0d", name, en_cyc.size() - e0, exp_en.size()); end
        tests++;
        if (s_data.size() - s0 != exp_sc.size()) begin fails++;
            $display("FAIL %s sample_count: got %0d expected %0d", name, s_data.size() - s0, exp_sc.size()); end
        tests++;
        if (d_val.size() - d0 != exp_dc.size()) begin fails++;
            $display("FAIL %s done_count: got %0d expected %0d", name, d_val.size() - d0, exp_dc.size()); end
        for (int k = 0; k < exp_g.size() && g0 + k < g_val.size(); k++) begin
            tests++;
            if (g_val[g0+k] !== exp_g[k] || g_cyc[g0+k] != exp_gc[k]) begin fails++;
                $display("FAIL %s grant[%0d]: got %b @%0d expected %b @%0d", name, k, g_val[g0+k], g_cyc[g0+k], exp_g[k], exp_gc[k]); end
        end
        for (int k = 0; k < exp_en.size() && e0 + k < en_cyc.size(); k++) begin
            tests++;
            if (en_cyc[e0+k] != exp_en[k]) begin fails++;
                $display("FAIL %s urng_en[%0d]: got cycle %0d expected %0d", name, k, en_cyc[e0+k], exp_en[k]); end
        end
        for (int k = 0; k < exp_sc.size() && s0 + k < s_data.size(); k++) begin
            tests++;
            if (s_cyc[s0+k] != exp_sc[k] || s_dst[s0+k] !== exp_sd[k]) begin fails++;
                $display("FAIL %s sample_route[%0d]: got dst %b @%0d expected %b @%0d", name, k, s_dst[s0+k], s_cyc[s0+k], exp_sd[k], exp_sc[k]); end
            if (p0 + k < p_data.size()) begin
                tests++;
                if (s_data[s0+k] !== p_data[p0+k]) begin fails++;
                    $display("FAIL %s sample_data[%0d]: got %h expected %h", name, k, s_data[s0+k], p_data[p0+k]); end
            end
        end
        for (int k = 0; k < exp_dc.size() && d0 + k < d_val.size(); k++) begin
            tests++;
            if (d_val[d0+k] !== exp_g[k] || d_cyc[d0+k] != exp_dc[k]) begin fails++;
                $display("FAIL %s done[%0d]: got %b @%0d expected %b @%0d", name, k, d_val[d0+k], d_cyc[d0+k], exp_g[k], exp_dc[k]); end
        end
        tests++;
        if (busy !== 1'b0 || err !== 1'b0) begin fails++;
            $display("FAIL %s end_state: got busy=%b err=%b expected 0 0", name, busy, err); end
    endtask

    task automatic test_reset_mid_burst();
        int seen, rc, late_s, late_e;
        bit timeout;
        req_cnt = '0;
        req_cnt[CNT_W-1:0] = CNT_W'(10);
        req = 4'b0001;
        seen = 0;
        timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (grant != '0) req = '0;
            if (urng_en) seen++;
            if (seen >= 4) begin timeout = 1'b0; break; end
        end
        tests++;
        if (timeout) begin fails++; $display("FAIL rst_mid_start: got %0d issue cycles, expected 4", seen); end
        rst = 1'b0;
        req = '0;
        tick();
        rc = cyc;
        tests++;
        if ({grant, done, sample_dst, sample_valid, urng_en, busy, err, sample_data} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got grant=%b done=%b dst=%b sv=%b en=%b busy=%b err=%b data=%h, expected all 0",
                     grant, done, sample_dst, sample_valid, urng_en, busy, err, sample_data);
        end
        rst = 1'b1;
        model_rr = NREQ - 1;
        repeat (15) tick();
        late_s = 0;
        late_e = 0;
        foreach (s_cyc[i]) if (s_cyc[i] > rc) late_s++;
        foreach (en_cyc[i]) if (en_cyc[i] > rc) late_e++;
        tests++;
        if (late_s != 0) begin fails++; $display("FAIL rst_mid_samples: got %0d samples after reset, expected 0", late_s); end
        tests++;
        if (late_e != 0) begin fails++; $display("FAIL rst_mid_issue: got %0d urng_en after reset, expected 0", late_e); end
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin fails++;
            $display("FAIL rst_mid_state: got err=%b busy=%b expected 0 0", err, busy); end
    endtask

    task automatic test_pipe_fault();
        bit timeout;
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL fault_pre_err: got %b expected 0", err); end
        drop_req = drop_req + 1;
        req_cnt = '0;
        req_cnt[CNT_W-1:0] = CNT_W'(4);
        req = 4'b0001;
        timeout = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (grant != '0) req = '0;
            if (req == '0 && !busy) begin timeout = 1'b0; break; end
        end
        req = '0;
        tests++;
        if (timeout) begin fails++; $display("FAIL fault_timeout: got busy, expected idle"); end
        repeat (3) tick();
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL fault_err: got %b expected 1", err); end
        repeat (5) tick();
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL fault_sticky: got %b expected 1", err); end
        rst = 1'b0;
        tick();
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL fault_cleared: got %b expected 0", err); end
        rst = 1'b1;
        model_rr = NREQ - 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_bursts("single", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, 1, 100);
        test_reset();
        test_bursts("round_robin", 4'b1111, {4{8'd2}}, 5, 200);
        test_bursts("zero_len", 4'b0100, '0, 1, 20);
        test_bursts("max_burst", 4'b0010, {8'd0, 8'd0, 8'd255, 8'd0}, 1, 400);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++)
                rnd_cnts[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
            test_bursts("random", NREQ'($urandom_range(1, (1 << NREQ) - 1)), rnd_cnts,
                        int'($urandom_range(1, 6)), 800);
        end
        test_reset_mid_burst();
        test_pipe_fault();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
